// File: rtl/pointer.sv
// Word-wide address pointer (e.g. a program counter): absolute load or signed relative move.
// Define POINTER_OVF_FLAG_EN to add a registered one-cycle `ovf` pulse when an update wraps.
module pointer #(
  parameter int                   WORD_SIZE   = 32,
  parameter logic [WORD_SIZE-1:0] RESET_VALUE = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [WORD_SIZE-1:0]        out,
  input  logic signed [WORD_SIZE-1:0] val,
  input  logic                        set_enable,
  input  logic                        update_enable
`ifdef POINTER_OVF_FLAG_EN
  ,
  output logic                        ovf
`endif
);

  logic [WORD_SIZE-1:0] sum;

`ifdef POINTER_OVF_FLAG_EN
  // Exact result is computed two bits wider so a wrap in either direction shows in the top bits.
  logic [WORD_SIZE+1:0] sum_ext;

  assign sum_ext = {2'b00, out} + {{2{val[WORD_SIZE-1]}}, val};
  assign sum     = sum_ext[WORD_SIZE-1:0];

  always_ff @(posedge clk) begin
    if (rst || set_enable || !update_enable) ovf <= 1'b0;
    else                                     ovf <= |sum_ext[WORD_SIZE+1:WORD_SIZE];
  end
`else
  assign sum = out + val;
`endif

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)                out <= RESET_VALUE;
    else if (set_enable)    out <= val;
    else if (update_enable) out <= sum;
  end

endmodule

// File: tb/tb_pointer.sv
// Directed self-checking bench for pointer; checks `ovf` too when POINTER_OVF_FLAG_EN is defined.
module tb_pointer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] out;
  logic [31:0] val;
  logic        set_enable;
  logic        update_enable;
`ifdef POINTER_OVF_FLAG_EN
  logic        ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pointer #(.WORD_SIZE(32), .RESET_VALUE(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .out           (out),
    .val           (val),
    .set_enable    (set_enable),
    .update_enable (update_enable)
`ifdef POINTER_OVF_FLAG_EN
    ,
    .ovf           (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Apply inputs, take one rising edge, then let outputs settle before sampling.
  task automatic step(input logic r, input logic s, input logic u, input logic [31:0] v);
    rst = r; set_enable = s; update_enable = u; val = v;
    @(posedge clk);
    #1;
  endtask

  task automatic check_ovf(input string tag, input logic expected);
`ifdef POINTER_OVF_FLAG_EN
    check(tag, {31'b0, ovf}, {31'b0, expected});
`endif
  endtask

  initial begin
    rst = 1'b0; set_enable = 1'b0; update_enable = 1'b0; val = '0;
    @(negedge clk);

    // Reset beats a simultaneous set, then the pointer holds.
    step(1'b1, 1'b1, 1'b0, 32'h55);     check("reset_wins", out, 32'h0);
    check_ovf("reset_ovf", 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h55);   check("hold_after_reset", out, 32'h0);
    end

    // Incrementing by one.
    step(1'b0, 1'b0, 1'b1, 32'h1);      check("update_1", out, 32'h1);
    check_ovf("update_1_ovf", 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h1);      check("update_2", out, 32'h2);
    step(1'b0, 1'b0, 1'b1, 32'h1);      check("update_3", out, 32'h3);

    // Absolute load followed by a negative offset.
    step(1'b0, 1'b1, 1'b0, 32'h3);      check("set_3", out, 32'h3);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE); check("update_neg2", out, 32'h1);
    check_ovf("neg_no_wrap_ovf", 1'b0);

    // Set has priority over update.
    step(1'b0, 1'b1, 1'b0, 32'h10);     check("set_10", out, 32'h10);
    step(1'b0, 1'b1, 1'b1, 32'h20);     check("set_beats_update", out, 32'h20);

    // Wrap in both directions.
    step(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF); check("set_max", out, 32'hFFFF_FFFF);
    check_ovf("set_ovf", 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h1);      check("wrap_up", out, 32'h0);
    check_ovf("wrap_up_ovf", 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF); check("wrap_down", out, 32'hFFFF_FFFF);
    check_ovf("wrap_down_ovf", 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h1);      check("hold_max", out, 32'hFFFF_FFFF);
    check_ovf("hold_ovf", 1'b0);

    // Counting by 4, reset mid-sequence, then resume from the reset value.
    step(1'b0, 1'b0, 1'b1, 32'h4);      check("count4_a", out, 32'h3);
    check_ovf("count4_wrap_ovf", 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h4);      check("count4_b", out, 32'h7);
    check_ovf("count4_no_wrap_ovf", 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h4);      check("count4_c", out, 32'hB);
    step(1'b1, 1'b0, 1'b1, 32'h4);      check("mid_reset", out, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h4);      check("resume_4", out, 32'h4);
    step(1'b0, 1'b0, 1'b1, 32'h4);      check("resume_8", out, 32'h8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
